// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch / decode / execute / writeback control FSM.
// Stops in a sticky BREAK state on HALT, illegal opcode, ALU timeout or debug halt.
module core_sequencer #(
    parameter int unsigned       ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]       HALT_WORD = 32'h0010_0073,
    parameter int unsigned       MAX_EXEC  = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              alu_start,
    input  logic              alu_done,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    input  logic              dbg_halt_req,
    output logic [2:0]        state,
    output logic              halted,
    output logic [1:0]        cause,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       retired
);

    localparam int unsigned      CNT_W     = 8;
    localparam logic [CNT_W-1:0] LAST_EXEC = CNT_W'(MAX_EXEC - 1);
    localparam logic [6:0]       OP_R      = 7'b0110011;
    localparam logic [6:0]       OP_I      = 7'b0010011;
    localparam logic [1:0]       C_NONE    = 2'b00;
    localparam logic [1:0]       C_HALT    = 2'b01;
    localparam logic [1:0]       C_ILL     = 2'b10;
    localparam logic [1:0]       C_TMO     = 2'b11;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'b001,
        ST_DECODE    = 3'b010,
        ST_EXECUTE   = 3'b011,
        ST_WRITEBACK = 3'b100,
        ST_BREAK     = 3'b110
    } state_t;

    state_t           st;
    logic [CNT_W-1:0] exec_cnt;

    // Fetch request is suppressed while reset is held even though st is already FETCH.
    assign imem_req  = (st == ST_FETCH) && !rst;
    assign imem_addr = pc;
    assign rf_waddr  = instr[11:7];
    assign state     = st;

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= ST_FETCH;
            pc        <= RESET_PC;
            instr     <= '0;
            retired   <= '0;
            cause     <= C_NONE;
            exec_cnt  <= '0;
            halted    <= 1'b0;
            rf_we     <= 1'b0;
            alu_start <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            rf_we     <= 1'b0;
            case (st)
                ST_FETCH: begin
                    if (dbg_halt_req) begin
                        st     <= ST_BREAK;
                        cause  <= C_HALT;
                        halted <= 1'b1;
                    end else if (imem_ack) begin
                        instr <= imem_rdata;
                        st    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (instr == HALT_WORD) begin
                        st     <= ST_BREAK;
                        cause  <= C_HALT;
                        halted <= 1'b1;
                    end else if (instr[6:0] == OP_R || instr[6:0] == OP_I) begin
                        st        <= ST_EXECUTE;
                        alu_start <= 1'b1;
                        exec_cnt  <= '0;
                    end else begin
                        st     <= ST_BREAK;
                        cause  <= C_ILL;
                        halted <= 1'b1;
                    end
                end
                ST_EXECUTE: begin
                    exec_cnt <= exec_cnt + CNT_W'(1);
                    // Done is ignored on the start cycle and beats a coincident timeout.
                    if (alu_done && exec_cnt != '0) begin
                        st    <= ST_WRITEBACK;
                        rf_we <= (instr[11:7] != 5'd0);
                    end else if (exec_cnt == LAST_EXEC) begin
                        st     <= ST_BREAK;
                        cause  <= C_TMO;
                        halted <= 1'b1;
                    end
                end
                ST_WRITEBACK: begin
                    pc      <= pc + ADDR_W'(1);
                    retired <= retired + 32'd1;
                    st      <= ST_FETCH;
                end
                ST_BREAK: begin
                end
                default: begin
                    st     <= ST_BREAK;
                    cause  <= C_ILL;
                    halted <= 1'b1;
                end
            endcase
        end
    end

endmodule
